// File: rtl/sched_pkg.sv
// Shared definitions for the row-window scheduler: frame geometry defaults,
// padded-row count, FSM state encoding and the slot one-hot helper.
package sched_pkg;

  localparam int unsigned IMG_W_DEF = 416;
  localparam int unsigned IMG_H_DEF = 416;
  localparam int unsigned PAD_ROWS  = 418;
  // Rows fetched beyond the output row count (top and bottom padding).
  localparam int unsigned PAD_EXTRA = PAD_ROWS - IMG_H_DEF;
  localparam int unsigned IDX_W     = 9;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned NSLOT     = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_SWEEP = 3'd2,
    ST_FETCH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // One-hot write strobe for a physical slot number.
  function automatic logic [NSLOT-1:0] slot_onehot(input logic [SEL_W-1:0] s);
    logic [NSLOT-1:0] oh;
    oh = '0;
    case (s)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/slot_rotator.sv
// Tracks which physical row slot holds window rows top/mid/bot.
// Ports: clk, reset (async active-low), init (restore 0/1/2 at frame start),
//        rotate (fetch transfer: oldest slot becomes the new bottom row),
//        sel_top/sel_mid/sel_bot (registered slot selects).
module slot_rotator
  import sched_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             rotate,
  output logic [SEL_W-1:0] sel_top,
  output logic [SEL_W-1:0] sel_mid,
  output logic [SEL_W-1:0] sel_bot
);

  // The slot just overwritten (old top) now carries the newest row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_top <= 2'd0;
      sel_mid <= 2'd1;
      sel_bot <= 2'd2;
    end else if (init) begin
      sel_top <= 2'd0;
      sel_mid <= 2'd1;
      sel_bot <= 2'd2;
    end else if (rotate) begin
      sel_top <= sel_mid;
      sel_mid <= sel_bot;
      sel_bot <= sel_top;
    end
  end

endmodule

// File: rtl/row_window_sched.sv
// Row-window scheduler: fetches padded rows into a 3-slot ring and sweeps
// 3x3 window positions across each output row for the conv engine.
// Ports: clk, reset (async active-low), start; row source handshake
//        row_req/row_idx/row_ack; slot_wr_en one-hot slot load strobe;
//        sel_top/sel_mid/sel_bot slot selects; window handshake
//        win_valid/win_ready with col_idx/out_row; busy, done pulse.
// Optional: define ROW_WINDOW_STALL_CNT_EN to add stall_cnt[31:0], a
//        saturating count of stalled handshake cycles, cleared on start.
module row_window_sched
  import sched_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             row_req,
  output logic [IDX_W-1:0] row_idx,
  input  logic             row_ack,
  output logic [NSLOT-1:0] slot_wr_en,
  output logic [SEL_W-1:0] sel_top,
  output logic [SEL_W-1:0] sel_mid,
  output logic [SEL_W-1:0] sel_bot,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [IDX_W-1:0] col_idx,
  output logic [IDX_W-1:0] out_row,
  output logic             busy,
  output logic             done
`ifdef ROW_WINDOW_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam logic [IDX_W-1:0] LAST_COL  = IDX_W'(IMG_W - 1);
  localparam logic [IDX_W-1:0] LAST_ROW  = IDX_W'(IMG_H - 1);
  localparam logic [SEL_W-1:0] LAST_FILL = SEL_W'(PAD_EXTRA);
  // Row fetched after finishing out_row r is padded row r+3.
  localparam logic [IDX_W-1:0] FETCH_OFS = IDX_W'(PAD_EXTRA + 1);

  state_t           state, state_next;
  logic [SEL_W-1:0] fill_q, fill_next;
  logic [IDX_W-1:0] col_q, col_next;
  logic [IDX_W-1:0] row_q, row_next;
  logic             init;
  logic             rotate;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      fill_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      state  <= state_next;
      fill_q <= fill_next;
      col_q  <= col_next;
      row_q  <= row_next;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_next = state;
    fill_next  = fill_q;
    col_next   = col_q;
    row_next   = row_q;
    row_req    = 1'b0;
    row_idx    = '0;
    slot_wr_en = '0;
    win_valid  = 1'b0;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    init       = 1'b0;
    rotate     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FILL;
          fill_next  = '0;
          col_next   = '0;
          row_next   = '0;
          init       = 1'b1;
        end
      end
      ST_FILL: begin
        row_req = 1'b1;
        row_idx = IDX_W'(fill_q);
        if (row_ack) begin
          slot_wr_en = slot_onehot(fill_q);
          if (fill_q == LAST_FILL) begin
            fill_next  = '0;
            state_next = ST_SWEEP;
          end else begin
            fill_next = fill_q + 2'd1;
          end
        end
      end
      ST_SWEEP: begin
        win_valid = 1'b1;
        if (win_ready) begin
          if (col_q == LAST_COL) begin
            col_next   = '0;
            state_next = (row_q == LAST_ROW) ? ST_DONE : ST_FETCH;
          end else begin
            col_next = col_q + 9'd1;
          end
        end
      end
      ST_FETCH: begin
        row_req = 1'b1;
        row_idx = row_q + FETCH_OFS;
        if (row_ack) begin
          // Newest row overwrites the slot that held the old top row.
          slot_wr_en = slot_onehot(sel_top);
          rotate     = 1'b1;
          row_next   = row_q + 9'd1;
          state_next = ST_SWEEP;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        col_next   = '0;
        row_next   = '0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign col_idx = col_q;
  assign out_row = row_q;

  slot_rotator u_slot_rotator (
    .clk     (clk),
    .reset   (reset),
    .init    (init),
    .rotate  (rotate),
    .sel_top (sel_top),
    .sel_mid (sel_mid),
    .sel_bot (sel_bot)
  );

`ifdef ROW_WINDOW_STALL_CNT_EN
  logic stall;
  assign stall = (win_valid & ~win_ready) | (row_req & ~row_ack);

  // Saturating stall counter, restarted with each accepted frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (init) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_row_window_sched.sv
// Directed bench for row_window_sched with a 4x4 output frame.
module tb_row_window_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       row_req;
  logic [8:0] row_idx;
  logic       row_ack;
  logic [2:0] slot_wr_en;
  logic [1:0] sel_top, sel_mid, sel_bot;
  logic       win_valid;
  logic       win_ready;
  logic [8:0] col_idx;
  logic [8:0] out_row;
  logic       busy;
  logic       done;
`ifdef ROW_WINDOW_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] idx_log[$];
  logic [2:0] wr_log[$];
  logic [5:0] sel_log[$];
  int         first_win;

  always #5 clk = ~clk;

  row_window_sched #(.IMG_W(4), .IMG_H(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .row_req    (row_req),
    .row_idx    (row_idx),
    .row_ack    (row_ack),
    .slot_wr_en (slot_wr_en),
    .sel_top    (sel_top),
    .sel_mid    (sel_mid),
    .sel_bot    (sel_bot),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .col_idx    (col_idx),
    .out_row    (out_row),
    .busy       (busy),
    .done       (done)
`ifdef ROW_WINDOW_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs (optionally starting) a frame with both handshakes always ready until done.
  task automatic run_frame(input bit do_start, input bit hold_start,
                           output int xfers, output int wins, output int dones,
                           output bit timed_out);
    bit fetch_seen;
    xfers = 0; wins = 0; dones = 0; timed_out = 1'b1; fetch_seen = 1'b0;
    idx_log.delete(); wr_log.delete(); sel_log.delete(); first_win = -1;
    row_ack = 1'b1; win_ready = 1'b1; start = do_start;
    for (int cyc = 0; cyc < 400; cyc++) begin
      #1;
      if (fetch_seen) begin
        sel_log.push_back({sel_top, sel_mid, sel_bot});
        fetch_seen = 1'b0;
      end
      if (row_req && row_ack) begin
        xfers++;
        idx_log.push_back(row_idx);
        wr_log.push_back(slot_wr_en);
        if (row_idx >= 9'd3) fetch_seen = 1'b1;
      end
      if (win_valid && win_ready) wins++;
      if (win_valid && first_win < 0) first_win = cyc;
      if (done) begin
        dones++;
        start = 1'b0;
        timed_out = 1'b0;
        break;
      end
      tick();
      start = hold_start;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; row_ack = 1'b0; win_ready = 1'b0;
    tick(); tick();
    #1;
    vectors++; if ({busy, row_req, win_valid, done} !== 4'b0000) begin miscompares++; $display("FAIL reset_ctrl got %b want 0000", {busy, row_req, win_valid, done}); end
    vectors++; if ({slot_wr_en, row_idx, col_idx, out_row} !== 30'd0) begin miscompares++; $display("FAIL reset_data got %h want 0", {slot_wr_en, row_idx, col_idx, out_row}); end
    vectors++; if ({sel_top, sel_mid, sel_bot} !== 6'b00_01_10) begin miscompares++; $display("FAIL reset_sel got %b want 000110", {sel_top, sel_mid, sel_bot}); end
`ifdef ROW_WINDOW_STALL_CNT_EN
    vectors++; if (stall_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
`endif
    tick();
    reset = 1'b1;
    tick(); tick();
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic_frame();
    int x, w, d; bit to;
    logic [2:0] exp_wr[6];
    logic [5:0] exp_sel[3];
    exp_wr  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_sel = '{6'b01_10_00, 6'b10_00_01, 6'b00_01_10};
    tick();
    run_frame(1'b1, 1'b0, x, w, d, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL basic_timeout got %b want 0", to); end
    vectors++; if (x !== 6) begin miscompares++; $display("FAIL basic_xfers got %0d want 6", x); end
    vectors++; if (w !== 16) begin miscompares++; $display("FAIL basic_windows got %0d want 16", w); end
    vectors++; if (d !== 1) begin miscompares++; $display("FAIL basic_done got %0d want 1", d); end
    vectors++; if (first_win !== 4) begin miscompares++; $display("FAIL basic_latency got %0d want 4", first_win); end
    vectors++; if (idx_log.size() !== 6) begin miscompares++; $display("FAIL basic_idx_count got %0d want 6", idx_log.size()); end
    for (int i = 0; i < 6 && i < idx_log.size(); i++) begin
      vectors++; if (idx_log[i] !== 9'(i)) begin miscompares++; $display("FAIL basic_row_idx[%0d] got %0d want %0d", i, idx_log[i], i); end
      vectors++; if (wr_log[i] !== exp_wr[i]) begin miscompares++; $display("FAIL basic_slot_wr[%0d] got %b want %b", i, wr_log[i], exp_wr[i]); end
    end
    vectors++; if (sel_log.size() !== 3) begin miscompares++; $display("FAIL basic_sel_count got %0d want 3", sel_log.size()); end
    for (int i = 0; i < 3 && i < sel_log.size(); i++) begin
      vectors++; if (sel_log[i] !== exp_sel[i]) begin miscompares++; $display("FAIL basic_sel[%0d] got %b want %b", i, sel_log[i], exp_sel[i]); end
    end
    tick();
    #1;
    vectors++; if ({busy, done, win_valid} !== 3'b000) begin miscompares++; $display("FAIL basic_post got %b want 000", {busy, done, win_valid}); end
  endtask

  task automatic test_ack_delay();
    int x, w, d; bit to;
    logic [2:0] oh;
    tick();
    start = 1'b1; row_ack = 1'b0; win_ready = 1'b1;
    #1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      oh = 3'b001 << k;
      for (int j = 0; j < 5; j++) begin
        #1;
        vectors++; if ({row_req, row_idx, slot_wr_en} !== {1'b1, 9'(k), 3'b000}) begin miscompares++; $display("FAIL fill_hold k%0d c%0d got %b/%0d/%b want 1/%0d/000", k, j, row_req, row_idx, slot_wr_en, k); end
        tick();
      end
      row_ack = 1'b1;
      #1;
      vectors++; if (slot_wr_en !== oh) begin miscompares++; $display("FAIL fill_strobe k%0d got %b want %b", k, slot_wr_en, oh); end
      tick();
      row_ack = 1'b0;
    end
    #1;
    vectors++; if ({win_valid, row_req, col_idx, out_row} !== {2'b10, 18'd0}) begin miscompares++; $display("FAIL fill_to_sweep got %b/%b/%0d/%0d want 1/0/0/0", win_valid, row_req, col_idx, out_row); end
    for (int c = 0; c < 20 && !row_req; c++) begin
      tick(); #1;
    end
    vectors++; if (row_req !== 1'b1) begin miscompares++; $display("FAIL fetch_reached got %b want 1", row_req); end
    for (int j = 0; j < 5; j++) begin
      vectors++; if ({row_req, row_idx, slot_wr_en, win_valid} !== {1'b1, 9'd3, 3'b000, 1'b0}) begin miscompares++; $display("FAIL fetch_hold c%0d got %b/%0d/%b/%b want 1/3/000/0", j, row_req, row_idx, slot_wr_en, win_valid); end
      tick(); #1;
    end
    row_ack = 1'b1;
    #1;
    vectors++; if (slot_wr_en !== 3'b001) begin miscompares++; $display("FAIL fetch_strobe got %b want 001", slot_wr_en); end
    run_frame(1'b0, 1'b0, x, w, d, to);
    vectors++; if ({to, d} !== {1'b0, 32'd1}) begin miscompares++; $display("FAIL ackdly_finish got to=%b done=%0d want to=0 done=1", to, d); end
  endtask

  task automatic test_ready_stall();
    int x, w, d; bit to;
    tick();
    start = 1'b1; row_ack = 1'b1; win_ready = 1'b1;
    #1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (win_valid && col_idx == 9'd2) break;
      tick();
    end
    vectors++; if ({win_valid, col_idx} !== {1'b1, 9'd2}) begin miscompares++; $display("FAIL stall_reach got %b/%0d want 1/2", win_valid, col_idx); end
    win_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if ({win_valid, col_idx} !== {1'b1, 9'd2}) begin miscompares++; $display("FAIL stall_hold c%0d got %b/%0d want 1/2", i, win_valid, col_idx); end
      tick();
    end
    win_ready = 1'b1;
    #1;
    vectors++; if (col_idx !== 9'd2) begin miscompares++; $display("FAIL stall_release got %0d want 2", col_idx); end
`ifdef ROW_WINDOW_STALL_CNT_EN
    vectors++; if (stall_cnt !== 32'd3) begin miscompares++; $display("FAIL stall_cnt got %0d want 3", stall_cnt); end
`endif
    tick();
    #1;
    vectors++; if (col_idx !== 9'd3) begin miscompares++; $display("FAIL stall_advance got %0d want 3", col_idx); end
    run_frame(1'b0, 1'b0, x, w, d, to);
    vectors++; if ({to, d} !== {1'b0, 32'd1}) begin miscompares++; $display("FAIL stall_finish got to=%b done=%0d want to=0 done=1", to, d); end
  endtask

  task automatic test_start_ignored();
    int x, w, d; bit to;
    tick();
    run_frame(1'b1, 1'b1, x, w, d, to);
    vectors++; if ({to, x, w, d} !== {1'b0, 32'd6, 32'd16, 32'd1}) begin miscompares++; $display("FAIL start_ignored got to=%b x=%0d w=%0d d=%0d want 0/6/16/1", to, x, w, d); end
    for (int i = 0; i < 6 && i < idx_log.size(); i++) begin
      vectors++; if (idx_log[i] !== 9'(i)) begin miscompares++; $display("FAIL start_ignored_idx[%0d] got %0d want %0d", i, idx_log[i], i); end
    end
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL start_ignored_idle c%0d got %b want 00", i, {busy, done}); end
    end
  endtask

  task automatic test_mid_reset();
    int x, w, d; bit to;
    tick();
    start = 1'b1; row_ack = 1'b1; win_ready = 1'b1;
    #1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (win_valid && out_row == 9'd2 && col_idx == 9'd1) break;
      tick();
    end
    vectors++; if ({win_valid, out_row, col_idx} !== {1'b1, 9'd2, 9'd1}) begin miscompares++; $display("FAIL midrst_reach got %b/%0d/%0d want 1/2/1", win_valid, out_row, col_idx); end
    reset = 1'b0;
    #1;
    vectors++; if ({busy, win_valid, row_req, out_row, col_idx} !== 21'd0) begin miscompares++; $display("FAIL midrst_async got %b/%b/%b/%0d/%0d want all 0", busy, win_valid, row_req, out_row, col_idx); end
    vectors++; if ({sel_top, sel_mid, sel_bot} !== 6'b00_01_10) begin miscompares++; $display("FAIL midrst_sel got %b want 000110", {sel_top, sel_mid, sel_bot}); end
    tick();
    #1;
    vectors++; if ({busy, win_valid} !== 2'b00) begin miscompares++; $display("FAIL midrst_next got %b want 00", {busy, win_valid}); end
    reset = 1'b1;
    tick();
    run_frame(1'b1, 1'b0, x, w, d, to);
    vectors++; if ({to, x, w, d} !== {1'b0, 32'd6, 32'd16, 32'd1}) begin miscompares++; $display("FAIL midrst_frame got to=%b x=%0d w=%0d d=%0d want 0/6/16/1", to, x, w, d); end
    vectors++; if (idx_log.size() > 0 && idx_log[0] !== 9'd0) begin miscompares++; $display("FAIL midrst_first_row got %0d want 0", idx_log[0]); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_ack_delay();
    test_ready_stall();
    test_start_ignored();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
